dmem_arbiter: RTL and testbench

- Sequences the single-port 4096 x 64-bit data memory and shares it between two requesters: the pipeline memory stage (M) and a debug/loader port (D).
- Each access occupies the memory for MEM_LATENCY cycles.
- M is stalled until its access completes.
- Out-of-range addresses are rejected without touching memory and flagged so the memory stage can raise status 3 (SADR).

---
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response buses of the two requesters and the memory-side bus
interface dmem_arbiter_if;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_stall;
  logic        m_done;
  logic [63:0] m_rdata;
  logic        m_err;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_done;
  logic [63:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  modport slave (
    input  m_req, m_we, m_addr, m_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output m_stall, m_done, m_rdata, m_err, d_done, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output m_req, m_we, m_addr, m_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  m_stall, m_done, m_rdata, m_err, d_done, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the M stage and the debug port
module dmem_arbiter #(
  parameter int ADDR_LIMIT  = 4096,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  state_t        state, state_nx;
  logic          own_d, we_q, err_q, m_done_q, d_done_q, resp_err;
  logic [11:0]   addr_q;
  logic [63:0]   wdata_q, rdata_q, resp_rdata, sel_addr;
  logic [LW-1:0] busy;
  logic [SW-1:0] starve_cnt;
  logic          any_req, grant_d, grant, addr_ok, last, access;
  // arbitration: M wins ties unless D has already lost STARVE_MAX grants in a row
  always_comb begin
    any_req  = bus.m_req | bus.d_req;
    grant_d  = bus.d_req & (~bus.m_req | (starve_cnt == SW'(STARVE_MAX)));
    grant    = (state == IDLE) && any_req;
    sel_addr = grant_d ? bus.d_addr : bus.m_addr;
    addr_ok  = sel_addr < 64'(ADDR_LIMIT);
    last     = busy == LW'(MEM_LATENCY - 1);
    access   = state == ACCESS;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: bad addresses skip the memory entirely
  always_comb begin
    state_nx = state;
    if (grant) state_nx = addr_ok ? ACCESS : RESP;
    else if (access && last) state_nx = RESP;
    else if (state == RESP) state_nx = IDLE;
  end
  // latch the granted request, count access cycles, capture read data on the last one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      own_d      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      busy       <= '0;
      starve_cnt <= '0;
    end else if (grant) begin
      own_d      <= grant_d;
      we_q       <= grant_d ? bus.d_we : bus.m_we;
      err_q      <= ~addr_ok;
      addr_q     <= sel_addr[11:0];
      wdata_q    <= grant_d ? bus.d_wdata : bus.m_wdata;
      rdata_q    <= '0;
      busy       <= '0;
      starve_cnt <= grant_d ? '0 :
                    (bus.d_req && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
    end else if (access) begin
      busy <= busy + 1'b1;
      if (last) rdata_q <= we_q ? '0 : bus.mem_rdata;
    end
  // registered one-cycle response to the owner, issued the cycle after RESP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      m_done_q   <= (state == RESP) && !own_d;
      d_done_q   <= (state == RESP) && own_d;
      resp_err   <= (state == RESP) && err_q;
      resp_rdata <= (state == RESP) ? rdata_q : '0;
    end
  // outputs are zero outside their qualifying cycles; stall is forced low during reset
  always_comb begin
    bus.m_stall   = rst_n & bus.m_req & ~m_done_q;
    bus.m_done    = m_done_q;
    bus.m_rdata   = m_done_q ? resp_rdata : '0;
    bus.m_err     = m_done_q & resp_err;
    bus.d_done    = d_done_q;
    bus.d_rdata   = d_done_q ? resp_rdata : '0;
    bus.d_err     = d_done_q & resp_err;
    bus.mem_en    = access;
    bus.mem_we    = access & we_q;
    bus.mem_addr  = access ? addr_q : '0;
    bus.mem_wdata = access ? wdata_q : '0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of latency, errors, arbitration and reset for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  logic [63:0] mem [4096];
  logic [63:0] rd;
  logic er;
  int lat, mcount, cyc, dn, en0;
  bit got_d;
  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  always @(posedge clk) if (bus.mem_en) en_cnt <= en_cnt + 1;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic acc(input bit dp, input logic we, input logic [63:0] addr, input logic [63:0] wd,
                     output logic [63:0] r, output logic e, output int l);
    if (dp) begin
      bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.m_req = 1; bus.m_we = we; bus.m_addr = addr; bus.m_wdata = wd;
    end
    l = 0;
    while (!(dp ? bus.d_done : bus.m_done) && l < 20) begin
      @(negedge clk);
      l++;
    end
    r = dp ? bus.d_rdata : bus.m_rdata;
    e = dp ? bus.d_err : bus.m_err;
    bus.m_req = 0;
    bus.d_req = 0;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 0;
    bus.m_req = 1; bus.m_we = 0; bus.m_addr = 0; bus.m_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (2) @(negedge clk);
    check("rst_stall", bus.m_stall, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_m_done", bus.m_done, 0);
    check("rst_d_done", bus.d_done, 0);
    bus.m_req = 0;
    rst_n = 1;
    @(negedge clk);
    check("idle_mem_en", bus.mem_en, 0);
    acc(1, 1, 64'h10, 64'hDEADBEEF, rd, er, lat);
    check("d_wr_lat", lat, 4);
    check("d_wr_err", er, 0);
    bus.m_req = 1; bus.m_we = 0; bus.m_addr = 64'h10;
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      check($sformatf("rd_stall_c%0d", n), bus.m_stall, n < 4);
      check($sformatf("rd_mem_en_c%0d", n), bus.mem_en, n == 1 || n == 2);
      check($sformatf("rd_mem_addr_c%0d", n), bus.mem_addr, (n == 1 || n == 2) ? 12'h10 : 12'h0);
      check($sformatf("rd_m_done_c%0d", n), bus.m_done, n == 4);
    end
    check("rd_rdata", bus.m_rdata, 64'hDEADBEEF);
    check("rd_err", bus.m_err, 0);
    check("rd_d_quiet", bus.d_done, 0);
    bus.m_req = 0;
    @(negedge clk);
    check("rd_done_pulse", bus.m_done, 0);
    check("rd_no_regrant", bus.mem_en, 0);
    acc(0, 1, 64'd4095, 64'h55, rd, er, lat);
    check("wr4095_lat", lat, 4);
    check("wr4095_err", er, 0);
    acc(0, 0, 64'd4095, 64'h0, rd, er, lat);
    check("rd4095_data", rd, 64'h55);
    check("rd4095_err", er, 0);
    en0 = en_cnt;
    acc(0, 0, 64'd4096, 64'h0, rd, er, lat);
    check("err4096_lat", lat, 2);
    check("err4096_err", er, 1);
    check("err4096_rdata", rd, 0);
    check("err4096_no_mem", en_cnt - en0, 0);
    en0 = en_cnt;
    acc(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, rd, er, lat);
    check("errmax_lat", lat, 2);
    check("errmax_err", er, 1);
    check("errmax_rdata", rd, 0);
    check("errmax_no_mem", en_cnt - en0, 0);
    acc(1, 0, 64'd5000, 64'h0, rd, er, lat);
    check("d_err_lat", lat, 2);
    check("d_err_flag", er, 1);
    bus.m_req = 1; bus.m_we = 0; bus.m_addr = 64'h10;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'd4095;
    mcount = 0; cyc = 0; got_d = 0;
    while (!got_d && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.m_done) begin
        mcount++;
        check("cont_m_rdata", bus.m_rdata, 64'hDEADBEEF);
      end
      if (bus.d_done) got_d = 1;
    end
    check("cont_d_seen", got_d, 1);
    check("cont_m_before_d", mcount, 4);
    check("cont_d_cycle", cyc, 20);
    check("cont_d_rdata", bus.d_rdata, 64'h55);
    check("cont_m_quiet", bus.m_done, 0);
    check("cont_starve_cleared", dut.starve_cnt, 0);
    bus.d_req = 0;
    lat = 0;
    while (!bus.m_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("cont_next_m_lat", lat, 4);
    check("cont_next_m_rdata", bus.m_rdata, 64'hDEADBEEF);
    bus.m_req = 0;
    @(negedge clk);
    bus.m_req = 1; bus.m_we = 1; bus.m_addr = 64'd7; bus.m_wdata = 64'hAAAA;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_pre_en", bus.mem_en, 1);
    #2 rst_n = 0;
    #1;
    check("rstmid_mem_en", bus.mem_en, 0);
    check("rstmid_mem_we", bus.mem_we, 0);
    check("rstmid_mem_addr", bus.mem_addr, 0);
    check("rstmid_mem_wdata", bus.mem_wdata, 0);
    check("rstmid_stall", bus.m_stall, 0);
    check("rstmid_m_done", bus.m_done, 0);
    check("rstmid_state", dut.state, 0);
    bus.m_req = 0;
    @(negedge clk);
    rst_n = 1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.m_done) dn++;
    end
    check("rstmid_no_done", dn, 0);
    check("rstmid_idle", dut.state, 0);
    acc(0, 0, 64'h10, 64'h0, rd, er, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_rdata", rd, 64'hDEADBEEF);
    check("post_rst_err", er, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
